// File: rtl/spi_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_arb : round-robin arbiter sharing one SPI monarch between requester 0
//           (A2D) and requester 1 (inertial), with lock, select and MISO
//           steering. Optional BUSY watchdog: define SPI_ARB_TIMEOUT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt0,
    input  logic        wrt1,
    input  logic [15:0] wt_data0,
    input  logic [15:0] wt_data1,
    input  logic        lock0,
    input  logic        lock1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data0,
    output logic [15:0] rd_data1,
    output logic        spi_wrt,
    output logic [15:0] spi_wt_data,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    input  logic        spi_SS_n,
    output logic        SS0_n,
    output logic        SS1_n,
    input  logic        MISO0,
    input  logic        MISO1,
    output logic        MISO,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_BUSY  = 3'd2,
        S_GAP   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        pend0_q, pend0_d, pend1_q, pend1_d;
    logic [15:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] wt_q, wt_d;
    logic [15:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic        done0_q, done0_d, done1_q, done1_d;

    logic        grant_w;
    logic        own_pend_w;
    logic        own_lock_w;
    logic        bus_active_w;
    logic        timeout_w;

    assign grant_w    = (pend0_q & pend1_q) ? ~last_q : pend1_q;
    assign own_pend_w = owner_q ? pend1_q : pend0_q;
    assign own_lock_w = owner_q ? lock1 : lock0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wt_d    = wt_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        // A request that arrives while one is already pending is dropped.
        pend0_d = pend0_q | wrt0;
        pend1_d = pend1_q | wrt1;
        hold0_d = (wrt0 && !pend0_q) ? wt_data0 : hold0_q;
        hold1_d = (wrt1 && !pend1_q) ? wt_data1 : hold1_q;

        case (state_q)
            S_IDLE: begin
                if (pend0_q || pend1_q) begin
                    owner_d = grant_w;
                    wt_d    = grant_w ? hold1_q : hold0_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (owner_q) pend1_d = 1'b0;
                else         pend0_d = 1'b0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (spi_done) begin
                    if (owner_q) begin
                        rd1_d   = spi_rd_data;
                        done1_d = 1'b1;
                    end else begin
                        rd0_d   = spi_rd_data;
                        done0_d = 1'b1;
                    end
                    last_d  = owner_q;
                    state_d = own_lock_w ? S_HOLD : S_GAP;
                end else if (timeout_w) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            S_HOLD: begin
                // A locked owner keeps the bus; the other side waits.
                if (own_pend_w) begin
                    wt_d    = owner_q ? hold1_q : hold0_q;
                    state_d = S_ISSUE;
                end else if (!own_lock_w) begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            hold0_q <= 16'h0000;
            hold1_q <= 16'h0000;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            wt_q    <= 16'h0000;
            rd0_q   <= 16'h0000;
            rd1_q   <= 16'h0000;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wt_q    <= wt_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [11:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    assign timeout_w = (state_q == S_BUSY) && (tmo_q == 12'hFFF) && !spi_done;

    always_comb begin
        tmo_d = (state_q == S_BUSY) ? (tmo_q + 12'd1) : 12'd0;
        err_d = err_q | timeout_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 12'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout_w = 1'b0;
    assign err       = 1'b0;
`endif

    assign bus_active_w = (state_q != S_IDLE) && (state_q != S_GAP);

    assign spi_wrt     = (state_q == S_ISSUE);
    assign spi_wt_data = wt_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign rd_data0    = rd0_q;
    assign rd_data1    = rd1_q;
    assign SS0_n       = spi_SS_n | ~(bus_active_w & ~owner_q);
    assign SS1_n       = spi_SS_n | ~(bus_active_w &  owner_q);
    assign MISO        = (bus_active_w & owner_q) ? MISO1 : MISO0;

endmodule

`default_nettype wire

// File: tb/tb_spi_arb.sv
`default_nettype none
// tb_spi_arb: table of single transactions, hand sequences for arbitration
// corners, and a randomized run against a transaction-level scoreboard.
module tb_spi_arb;

    logic        clk, rst_n;
    logic        wrt0, wrt1, lock0, lock1;
    logic [15:0] wt_data0, wt_data1;
    logic        done0, done1;
    logic [15:0] rd_data0, rd_data1;
    logic        spi_wrt, spi_done;
    logic [15:0] spi_wt_data, spi_rd_data;
    logic        spi_SS_n, SS0_n, SS1_n, MISO0, MISO1, MISO, err;

    spi_arb dut (
        .clk(clk), .rst_n(rst_n),
        .wrt0(wrt0), .wrt1(wrt1),
        .wt_data0(wt_data0), .wt_data1(wt_data1),
        .lock0(lock0), .lock1(lock1),
        .done0(done0), .done1(done1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .spi_wrt(spi_wrt), .spi_wt_data(spi_wt_data),
        .spi_done(spi_done), .spi_rd_data(spi_rd_data),
        .spi_SS_n(spi_SS_n), .SS0_n(SS0_n), .SS1_n(SS1_n),
        .MISO0(MISO0), .MISO1(MISO1), .MISO(MISO),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct {
        logic        who;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        ssn;
        logic        m0;
        logic        m1;
        logic        e_ss0;
        logic        e_ss1;
        logic        e_miso;
    } vec_t;

    vec_t tbl[6];

    // scoreboard state for the randomized run
    bit          hp[2];
    logic [15:0] pc[2];
    int          pt[2];
    logic [15:0] rdm[2];
    bit          busy_m, own_m, last_m, exp_who;
    int          done_at, exp_done_at, n_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        wrt0 = 1'b0;
        wrt1 = 1'b0;
        spi_done = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic expect_issue(input int lat, input logic [15:0] d, input string nm);
        for (int i = 1; i <= lat; i++) begin
            next_cyc();
            mid();
            if (i < lat) chk({nm, "_early"}, 64'(spi_wrt), 64'd0);
            else         chk(nm, 64'({spi_wrt, spi_wt_data}), 64'({1'b1, d}));
        end
    endtask

    task automatic complete(input logic who, input logic [15:0] rd, input string nm);
        next_cyc();
        spi_done = 1'b1;
        spi_rd_data = rd;
        mid();
        chk({nm, "_nodone"}, 64'({done1, done0}), 64'd0);
        next_cyc();
        mid();
        chk(nm, 64'({done1, done0, (who ? rd_data1 : rd_data0)}), 64'({who, ~who, rd}));
    endtask

    task automatic rnd_cycle(input bit quiet);
        logic       e0, e1, pick;
        logic [1:0] exp_done;
        next_cyc();
        n_cyc++;
        if (!quiet) begin
            wrt0 = ($urandom_range(3) == 0);
            wrt1 = ($urandom_range(3) == 0);
        end
        wt_data0 = 16'($urandom);
        wt_data1 = 16'($urandom);
        spi_SS_n = 1'($urandom);
        MISO0    = 1'($urandom);
        MISO1    = 1'($urandom);
        if (busy_m && n_cyc == done_at) begin
            spi_done    = 1'b1;
            spi_rd_data = 16'($urandom);
        end
        mid();
        exp_done = (n_cyc == exp_done_at) ? (exp_who ? 2'b10 : 2'b01) : 2'b00;
        chk("rnd_done_rd", 64'({done1, done0, rd_data1, rd_data0, err}),
            64'({exp_done, rdm[1], rdm[0], 1'b0}));
        if (wrt0 && !hp[0]) begin hp[0] = 1'b1; pc[0] = wt_data0; pt[0] = n_cyc; end
        if (wrt1 && !hp[1]) begin hp[1] = 1'b1; pc[1] = wt_data1; pt[1] = n_cyc; end
        if (spi_wrt) begin
            e0 = hp[0] && (pt[0] <= n_cyc - 2);
            e1 = hp[1] && (pt[1] <= n_cyc - 2);
            chk("rnd_issue_legal", 64'({busy_m, e0 | e1}), 64'({1'b0, 1'b1}));
            pick = (e0 && e1) ? ~last_m : e1;
            chk("rnd_issue_data", 64'(spi_wt_data), 64'(pc[pick]));
            own_m   = pick;
            busy_m  = 1'b1;
            hp[pick] = 1'b0;
            done_at = n_cyc + int'($urandom_range(6, 1));
        end
        chk("rnd_ss_miso", 64'({SS0_n, SS1_n, MISO}),
            64'({spi_SS_n | ~(busy_m & ~own_m), spi_SS_n | ~(busy_m & own_m),
                 (busy_m & own_m) ? MISO1 : MISO0}));
        if (spi_done) begin
            rdm[own_m]  = spi_rd_data;
            exp_done_at = n_cyc + 1;
            exp_who     = own_m;
            last_m      = own_m;
            busy_m      = 1'b0;
        end
    endtask

    task automatic timeout_test();
`ifdef SPI_ARB_TIMEOUT_EN
        int waited;
        bit saw_done;
        next_cyc();
        wrt0 = 1'b1; wt_data0 = 16'h7000;
        mid();
        expect_issue(2, 16'h7000, "tmo_issue");
        next_cyc();
        wrt1 = 1'b1; wt_data1 = 16'h7111;
        mid();
        waited = 0;
        saw_done = 1'b0;
        while (!err && waited < 4300) begin
            next_cyc();
            mid();
            waited++;
            if (done0 || done1) saw_done = 1'b1;
        end
        chk("tmo_err_no_done", 64'({err, saw_done}), 64'({1'b1, 1'b0}));
        expect_issue(2, 16'h7111, "tmo_next_grant");
        complete(1'b1, 16'h7222, "tmo_next_done");
        chk("tmo_err_sticky", 64'(err), 64'd1);
`else
        bit saw;
        next_cyc();
        wrt0 = 1'b1; wt_data0 = 16'h7000;
        mid();
        expect_issue(2, 16'h7000, "tmo_issue");
        saw = 1'b0;
        for (int i = 0; i < 300; i++) begin
            next_cyc();
            mid();
            if (err || done0 || done1) saw = 1'b1;
        end
        chk("tmo_err_stays_low", 64'(saw), 64'd0);
        complete(1'b0, 16'h7333, "tmo_late_done");
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        tbl[0] = '{1'b0, 16'h2800, 16'h0ABC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 16'h0055, 16'hA5A5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h8001, 16'h1357, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        wrt0 = 1'b0; wrt1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        wt_data0 = 16'h5555; wt_data1 = 16'hAAAA;
        spi_done = 1'b0; spi_rd_data = 16'h0000;
        spi_SS_n = 1'b0; MISO0 = 1'b1; MISO1 = 1'b0;
        #22;
        chk("reset_state",
            64'({spi_wrt, done0, done1, err, SS0_n, SS1_n, MISO, rd_data0, rd_data1, spi_wt_data}),
            64'({4'b0000, 3'b111, 48'h0}));
        mid();
        rst_n = 1'b1;

        // simultaneous requests straight after reset: requester 0 wins
        next_cyc();
        wrt0 = 1'b1; wt_data0 = 16'hA000;
        wrt1 = 1'b1; wt_data1 = 16'hB000;
        mid();
        expect_issue(2, 16'hA000, "tie1_first");
        complete(1'b0, 16'h1234, "tie1_done0");
        expect_issue(2, 16'hB000, "tie1_second");
        complete(1'b1, 16'h5678, "tie1_done1");

        foreach (tbl[k]) begin
            next_cyc();
            spi_SS_n = 1'b1;
            if (tbl[k].who) begin wrt1 = 1'b1; wt_data1 = tbl[k].wd; end
            else            begin wrt0 = 1'b1; wt_data0 = tbl[k].wd; end
            mid();
            expect_issue(2, tbl[k].wd, "tbl_issue");
            next_cyc();
            spi_SS_n = tbl[k].ssn; MISO0 = tbl[k].m0; MISO1 = tbl[k].m1;
            mid();
            chk("tbl_route", 64'({SS0_n, SS1_n, MISO}),
                64'({tbl[k].e_ss0, tbl[k].e_ss1, tbl[k].e_miso}));
            complete(tbl[k].who, tbl[k].rd, "tbl_done");
            chk("tbl_gap_route", 64'({SS0_n, SS1_n, MISO}), 64'({2'b11, tbl[k].m0}));
            next_cyc();
            spi_SS_n = 1'b0;
            mid();
            chk("tbl_idle_route", 64'({SS0_n, SS1_n, MISO}), 64'({2'b11, tbl[k].m0}));
        end

        // last served was requester 0, so a tie now goes to requester 1
        next_cyc();
        wrt0 = 1'b1; wt_data0 = 16'hA100;
        wrt1 = 1'b1; wt_data1 = 16'hB100;
        mid();
        expect_issue(2, 16'hB100, "tie2_first");
        complete(1'b1, 16'h2222, "tie2_done1");
        expect_issue(2, 16'hA100, "tie2_second");
        complete(1'b0, 16'h3333, "tie2_done0");

        // locked owner keeps the bus ahead of a pending requester 1
        next_cyc();
        lock0 = 1'b1; spi_SS_n = 1'b0;
        wrt0 = 1'b1; wt_data0 = 16'hC001;
        mid();
        expect_issue(2, 16'hC001, "lock_first");
        next_cyc();
        wrt1 = 1'b1; wt_data1 = 16'hD001;
        mid();
        complete(1'b0, 16'h0101, "lock_done_a");
        next_cyc();
        wrt0 = 1'b1; wt_data0 = 16'hC002;
        mid();
        expect_issue(2, 16'hC002, "lock_reissue");
        chk("lock_ss", 64'({SS0_n, SS1_n}), 64'({1'b0, 1'b1}));
        next_cyc();
        lock0 = 1'b0;
        mid();
        complete(1'b0, 16'h0202, "lock_done_b");
        expect_issue(2, 16'hD001, "lock_then_r1");
        complete(1'b1, 16'h0303, "lock_r1_done");

        // second request from requester 1 while its first is pending is dropped
        next_cyc();
        wrt0 = 1'b1; wt_data0 = 16'hE000;
        mid();
        expect_issue(2, 16'hE000, "dbl_r0");
        next_cyc();
        wrt1 = 1'b1; wt_data1 = 16'h1111;
        mid();
        next_cyc();
        wrt1 = 1'b1; wt_data1 = 16'h2222;
        mid();
        complete(1'b0, 16'h0404, "dbl_r0_done");
        expect_issue(2, 16'h1111, "dbl_first_kept");
        complete(1'b1, 16'h0505, "dbl_r1_done");
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            mid();
            if (spi_wrt) cnt++;
        end
        chk("dbl_no_second", 64'(cnt), 64'd0);

        timeout_test();

        // asynchronous reset in the middle of a requester 1 transaction
        next_cyc();
        wrt1 = 1'b1; wt_data1 = 16'hF000;
        mid();
        expect_issue(2, 16'hF000, "rst_issue");
        next_cyc();
        spi_SS_n = 1'b0; MISO0 = 1'b0; MISO1 = 1'b1;
        mid();
        chk("pre_rst_route", 64'({SS1_n, MISO}), 64'({1'b0, 1'b1}));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst",
            64'({spi_wrt, done0, done1, err, SS0_n, SS1_n, MISO, rd_data0, rd_data1, spi_wt_data}),
            64'({4'b0000, 3'b110, 48'h0}));
        mid();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cyc();
            if (i == 1) begin spi_done = 1'b1; spi_rd_data = 16'hDEAD; end
            mid();
            chk("post_rst_quiet", 64'({done0, done1, spi_wrt, rd_data1}), 64'd0);
        end

        // randomized run from the post-reset state
        lock0 = 1'b0; lock1 = 1'b0;
        hp[0] = 1'b0; hp[1] = 1'b0;
        pt[0] = 0; pt[1] = 0;
        pc[0] = 16'h0; pc[1] = 16'h0;
        rdm[0] = 16'h0; rdm[1] = 16'h0;
        busy_m = 1'b0; own_m = 1'b0; last_m = 1'b1; exp_who = 1'b0;
        done_at = -1; exp_done_at = -1; n_cyc = 0;
        for (int i = 0; i < 3000; i++) rnd_cycle(1'b0);
        for (int i = 0; i < 80 && (busy_m || hp[0] || hp[1] || n_cyc < exp_done_at); i++)
            rnd_cycle(1'b1);
        chk("rnd_drained", 64'({busy_m, hp[0], hp[1]}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_arb.md
SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; one clock, asynchronous active-low reset.
REQ-003 SHALL have ports: wrt0 / wrt1  input  1  one-cycle transaction request from requester 0 (A2D) / 1 (inertial).
REQ-004 SHALL have ports: wt_data0 / wt_data1  input  16  command word, sampled with wrtN.
REQ-005 SHALL have ports: lock0 / lock1  input  1  requester keeps bus ownership after its current transaction.
REQ-006 SHALL have ports: done0 / done1  output  1  one-cycle completion pulse to requester N.
REQ-007 SHALL have ports: rd_data0 / rd_data1  output  16  registered read word for requester N.
REQ-008 SHALL have ports: spi_wrt  output  1  / spi_wt_data  output  16  / spi_done  input  1  / spi_rd_data  input  16, to the shared SPI monarch.
REQ-009 SHALL have ports: spi_SS_n  input  1  (from monarch); SS0_n / SS1_n  output  1  per-slave selects; MISO0 / MISO1  input  1; MISO  output  1  (to monarch).
REQ-010 SHALL have port: err  output  1  sticky timeout flag.

Function
REQ-011 SHALL capture wrtN into pending bit pendN and wt_dataN into a 16-bit holding register in any state; wrtN while pendN already set SHALL be ignored (first command kept).
REQ-012 SHALL implement states IDLE, ISSUE, BUSY, GAP, HOLD.
REQ-013 IDLE: if any pend set, select owner, go ISSUE; both set -> grant the requester not served last (round robin); none -> stay.
REQ-014 ISSUE: spi_wrt=1 for exactly one cycle, spi_wt_data = owner's holding register, clear owner's pend, go BUSY.
REQ-015 BUSY: on spi_done, latch spi_rd_data into rd_dataN of owner, pulse doneN next cycle, record owner as last served; go HOLD if lockN of owner high that cycle, else GAP.
REQ-016 GAP: one dead cycle, then IDLE.
REQ-017 HOLD: owner's pend set -> ISSUE (other requester never granted); owner's lock low and no owner pend -> GAP; other requester's pend stays pending.
REQ-018 Latency: wrtN sampled high with arbiter IDLE -> spi_wrt high exactly 2 cycles later; spi_done at cycle M -> doneN high in cycle M+1 with rd_dataN valid same cycle.
REQ-019 spi_wt_data SHALL be held stable from ISSUE through BUSY.
REQ-020 SSN_n = spi_SS_n OR (owner != N OR state in IDLE/GAP); non-owner select always high.
REQ-021 MISO = MISO of current owner; MISO0 when idle.
REQ-022 rd_dataN SHALL hold until the next completion for requester N; done pulses never go to the non-owner.
REQ-023 wrt from the owner during BUSY SHALL be pended and served after completion (via HOLD if locked, else via round robin).

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, pend0/pend1 0, holding registers 0, rd_data0/rd_data1 0, done0/done1 0, spi_wrt 0, err 0, last served = 1 (requester 0 wins first tie), owner = 0.
REQ-025 Reset mid-transaction SHALL abandon it; no done pulse issued for it after release.

Configuration
REQ-026 Macro SPI_ARB_TIMEOUT_EN defined: 12-bit counter clears on entering BUSY, increments each BUSY cycle; reaching 4095 without spi_done -> set err (sticky until reset), no doneN, drop ownership and lock, go GAP.
REQ-027 Macro undefined: no counter, err tied 0, BUSY waits indefinitely for spi_done.

Verification
REQ-028 Single: wrt0 with wt_data0=16'h2800, idle -> spi_wrt 2 cycles later with 16'h2800; spi_done with spi_rd_data=16'h0ABC -> done0 next cycle, rd_data0=16'h0ABC, SS1_n high throughout.
REQ-029 Simultaneous wrt0/wrt1 after reset -> requester 0 served first, requester 1 second with one GAP cycle between; repeat -> requester 1 first.
REQ-030 Lock: lock0 high, wrt0 again one cycle after done0 while wrt1 pending -> second A2D transaction issued before requester 1; requester 1 served after lock0 drops.
REQ-031 Double request: two wrt1 pulses (16'h1111 then 16'h2222) while bus busy with 0 -> only 16'h1111 issued.
REQ-032 With SPI_ARB_TIMEOUT_EN: spi_done withheld 4095 cycles -> err=1, no done0, pending wrt1 then granted; without macro err stays 0.
REQ-033 rst_n asserted during BUSY -> all outputs at reset values immediately; no done pulse after release.
